line_fetch_engine: RTL

LINE_FETCH_ENGINE -- requirements
Module: line_fetch_engine

---
 rtl/line_fetch_engine_if.sv | 51 +++++
 rtl/line_fetch_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/line_fetch_engine_if.sv
// line_fetch_engine_if: bundles the line-fetch request, the read-command and
// read-data bus, the pixel FIFO write port and the status flags of
// line_fetch_engine. The master modport is the engine's view. The slave
// modport is the view of the surrounding logic: the requester, the memory
// and the FIFO.
interface line_fetch_engine_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
);
   // line request from the fill sequencer
   logic              go;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  line_bytes;

   // read command channel
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic              rd_ack;

   // read data return
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   // pixel FIFO write side
   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              fifo_almost_full;

   // status
   logic              busy;
   logic              done;
   logic              overrun;

   modport master (
      input  go, start_addr, line_bytes,
      input  rd_ack, rd_data, rd_valid, fifo_almost_full,
      output rd_req, rd_addr, rd_len,
      output fifo_wr_en, fifo_wr_data,
      output busy, done, overrun
   );

   modport slave (
      output go, start_addr, line_bytes,
      output rd_ack, rd_data, rd_valid, fifo_almost_full,
      input  rd_req, rd_addr, rd_len,
      input  fifo_wr_en, fifo_wr_data,
      input  busy, done, overrun
   );
endinterface

// File: rtl/line_fetch_engine.sv
// line_fetch_engine: fetches one display line from memory into the pixel FIFO.
// A go pulse latches a byte address and a byte count. The count is rounded up
// to whole 4-byte beats. The line is then read with burst commands of at most
// BURST_LEN beats, and no command is raised while the FIFO lacks room for a
// full burst. Every returned beat is written to the FIFO one cycle later.
// A go that arrives while a line is in flight is dropped and flagged by a
// one-cycle overrun pulse.
//
// Build option: define LINE_FETCH_PIXEL_SWAP_EN to swap the two 16-bit
// RGB565 pixels of each beat on their way into the FIFO. When it is left
// undefined, beats are written unchanged.
module line_fetch_engine #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int BURST_LEN = 16
) (
   input logic                 clk,
   input logic                 reset,   // synchronous, active low
   line_fetch_engine_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int               HALF_W        = DATA_W / 2;
   localparam logic [LEN_W-1:0] BURST_LEN_REM = LEN_W'(BURST_LEN);
   localparam logic [7:0]       BURST_LEN_CMD = 8'(BURST_LEN);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;        // address of the next command
   logic [LEN_W-1:0]  remaining_q;   // beats of the line not yet received
   logic [7:0]        burst_q;       // beats of the current burst not yet received

   logic              rd_req_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [7:0]        rd_len_q;
   logic              fifo_wr_en_q;
   logic [DATA_W-1:0] fifo_wr_data_q;
   logic              busy_q;
   logic              done_q;
   logic              overrun_q;

   logic [LEN_W-1:0]  beats_total_d;
   logic [7:0]        next_len_d;
   logic [ADDR_W-1:0] addr_step_d;
   logic [DATA_W-1:0] wr_word_d;

   // Beats per line: whole words plus one more for any trailing partial word.
   assign beats_total_d = {2'b00, bus.line_bytes[LEN_W-1:2]}
                        + {{(LEN_W-1){1'b0}}, |bus.line_bytes[1:0]};

   // Byte distance covered by the command in flight.
   assign addr_step_d = {{(ADDR_W-10){1'b0}}, rd_len_q, 2'b00};

   // Length of the next command: a full burst, or whatever is left of the line.
   always_comb begin
      next_len_d = BURST_LEN_CMD;
      if (remaining_q < BURST_LEN_REM) begin
         next_len_d = remaining_q[7:0];
      end
   end

`ifdef LINE_FETCH_PIXEL_SWAP_EN
   // Swap the two RGB565 pixels carried by each beat.
   assign wr_word_d = {bus.rd_data[HALF_W-1:0], bus.rd_data[DATA_W-1:HALF_W]};
`else
   // Beats go into the FIFO exactly as the memory returned them.
   assign wr_word_d = bus.rd_data;
`endif

   // Line sequencer: state, line bookkeeping and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         remaining_q    <= '0;
         burst_q        <= '0;
         rd_req_q       <= 1'b0;
         rd_addr_q      <= '0;
         rd_len_q       <= '0;
         fifo_wr_en_q   <= 1'b0;
         fifo_wr_data_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         fifo_wr_en_q <= 1'b0;
         // A request is accepted only in IDLE. Anywhere else it is dropped,
         // and the latched line is left untouched.
         overrun_q    <= bus.go && (state_q != ST_IDLE);

         case (state_q)
            ST_IDLE: begin
               if (bus.go) begin
                  addr_q      <= bus.start_addr;
                  remaining_q <= beats_total_d;
                  busy_q      <= 1'b1;
                  state_q     <= (beats_total_d == '0) ? ST_DONE : ST_REQ;
               end
            end

            ST_REQ: begin
               if (rd_req_q) begin
                  // A raised command stays frozen until the memory takes it.
                  if (bus.rd_ack) begin
                     rd_req_q <= 1'b0;
                     addr_q   <= addr_q + addr_step_d;
                     burst_q  <= rd_len_q;
                     state_q  <= ST_DATA;
                  end
               end else if (!bus.fifo_almost_full) begin
                  rd_req_q  <= 1'b1;
                  rd_addr_q <= addr_q;
                  rd_len_q  <= next_len_d;
               end
            end

            ST_DATA: begin
               if (bus.rd_valid) begin
                  fifo_wr_en_q   <= 1'b1;
                  fifo_wr_data_q <= wr_word_d;
                  burst_q        <= burst_q - 8'd1;
                  remaining_q    <= remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
                  if (burst_q == 8'd1) begin
                     state_q <= (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1}) ? ST_DONE : ST_REQ;
                  end
               end
            end

            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_req       = rd_req_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.rd_len       = rd_len_q;
   assign bus.fifo_wr_en   = fifo_wr_en_q;
   assign bus.fifo_wr_data = fifo_wr_data_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.overrun      = overrun_q;

endmodule
